// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_pkg
// Purpose  : Shared register-index sizing for the ID-stage hazard logic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;
    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_pending_counter.sv
//------------------------------------------------------------------------------
// Module   : pending_counter
// Purpose  : Per-register outstanding-write counter; holds at 0 and at max.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;
    logic             w_full;

    assign w_zero = (r_cnt == '0);
    assign w_full = (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && !dec && !w_full) begin
            r_cnt <= r_cnt + c_one;
        end else if (dec && !inc && !w_zero) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign count     = r_cnt;
    assign full      = w_full;
    assign underflow = dec && !inc && w_zero;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : hazard_scoreboard
// Purpose  : Pending-write scoreboard driving the IF/ID stall request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard #(
    parameter int NUM_REGS   = hazard_pkg::NUM_REGS,
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int CNT_W      = hazard_pkg::CNT_W,
    parameter int FWD_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic                  issue_is_load,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  hazard,
    output logic                  issue_fire,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  underflow_err
);

    logic [CNT_W-1:0]      w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   w_inc;
    logic [NUM_REGS-1:0]   w_dec;
    logic [NUM_REGS-1:0]   w_full;
    logic [NUM_REGS-1:0]   w_uf;

    logic                  r_ld_q;
    logic [REG_ADDR_W-1:0] r_ld_dest;
    logic                  r_underflow;

    logic w_src_hit1, w_src_hit2;
    logic w_haz_nofwd, w_haz_fwd, w_data_haz, w_struct_haz;
    logic w_hazard, w_fire;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            assign w_inc[gi]    = w_fire && issue_wb_en && (issue_dest == REG_ADDR_W'(gi));
            assign w_dec[gi]    = wb_valid && (wb_dest == REG_ADDR_W'(gi));
            assign busy_vec[gi] = |w_cnt[gi];

            pending_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (w_inc[gi]),
                .dec       (w_dec[gi]),
                .count     (w_cnt[gi]),
                .full      (w_full[gi]),
                .underflow (w_uf[gi])
            );
        end
    endgenerate

    assign w_src_hit1  = (w_cnt[src1] != '0);
    assign w_src_hit2  = two_src && (w_cnt[src2] != '0);
    assign w_haz_nofwd = issue_valid && (w_src_hit1 || w_src_hit2);
    assign w_haz_fwd   = issue_valid && r_ld_q &&
                         ((src1 == r_ld_dest) || (two_src && (src2 == r_ld_dest)));
    assign w_data_haz  = (FWD_EN != 0) ? w_haz_fwd : w_haz_nofwd;

    // A writeback to the same register this cycle frees the slot the issue needs.
    assign w_struct_haz = issue_valid && issue_wb_en && w_full[issue_dest] &&
                          !(wb_valid && (wb_dest == issue_dest));

    assign w_hazard = w_data_haz || w_struct_haz;
    assign w_fire   = issue_valid && !w_hazard;

    // A stalled cycle never fires, so the load-use window closes after one stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_q      <= 1'b0;
            r_ld_dest   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_ld_q      <= w_fire && issue_wb_en && issue_is_load;
            r_ld_dest   <= issue_dest;
            r_underflow <= r_underflow || (|w_uf);
        end
    end

    assign hazard        = w_hazard;
    assign issue_fire    = w_fire;
    assign underflow_err = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard, both forwarding modes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_scoreboard;
    import hazard_pkg::*;

    typedef struct packed {
        logic     rs, iv, we, ld;
        reg_idx_t dest, s1, s2;
        logic     two, wv;
        reg_idx_t wd;
    } stim_t;

    typedef struct packed {
        logic                haz;
        logic                fire;
        logic [NUM_REGS-1:0] busy;
        logic                uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    reg_idx_t src1 = '0, src2 = '0, issue_dest = '0, wb_dest = '0;
    logic two_src = 1'b0, issue_valid = 1'b0, issue_wb_en = 1'b0;
    logic issue_is_load = 1'b0, wb_valid = 1'b0;

    logic hazard0, fire0, uf0, hazard1, fire1, uf1;
    logic [NUM_REGS-1:0] busy0, busy1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .REG_ADDR_W(REG_ADDR_W), .CNT_W(2), .FWD_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_is_load(issue_is_load),
        .issue_dest(issue_dest), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .hazard(hazard0), .issue_fire(fire0), .busy_vec(busy0), .underflow_err(uf0)
    );

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .REG_ADDR_W(REG_ADDR_W), .CNT_W(2), .FWD_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_is_load(issue_is_load),
        .issue_dest(issue_dest), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .hazard(hazard1), .issue_fire(fire1), .busy_vec(busy1), .underflow_err(uf1)
    );

    function automatic stim_t mk(input logic rs, iv, we, ld, input int dest, s1, s2,
                                 input logic two, wv, input int wd);
        mk = '{rs, iv, we, ld, reg_idx_t'(dest), reg_idx_t'(s1), reg_idx_t'(s2),
               two, wv, reg_idx_t'(wd)};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rs; issue_valid = s.iv; issue_wb_en = s.we; issue_is_load = s.ld;
        issue_dest = s.dest; src1 = s.s1; src2 = s.s2; two_src = s.two;
        wb_valid = s.wv; wb_dest = s.wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            apply(mk(0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
            sb.push_back('{1'b0, 1'b1, 16'h0000, 1'b0});
            #2;
            e = sb.pop_front();
            checks++; if (hazard0 !== e.haz)  begin errors++; $display("FAIL reset[%0d] hazard0 got %b exp %b", i, hazard0, e.haz); end
            checks++; if (fire0 !== e.fire)   begin errors++; $display("FAIL reset[%0d] fire0 got %b exp %b", i, fire0, e.fire); end
            checks++; if (busy0 !== e.busy)   begin errors++; $display("FAIL reset[%0d] busy0 got %h exp %h", i, busy0, e.busy); end
            checks++; if (uf0 !== e.uf)       begin errors++; $display("FAIL reset[%0d] uf0 got %b exp %b", i, uf0, e.uf); end
            checks++; if (hazard1 !== e.haz)  begin errors++; $display("FAIL reset[%0d] hazard1 got %b exp %b", i, hazard1, e.haz); end
            checks++; if (busy1 !== e.busy)   begin errors++; $display("FAIL reset[%0d] busy1 got %h exp %h", i, busy1, e.busy); end
            checks++; if (uf1 !== e.uf)       begin errors++; $display("FAIL reset[%0d] uf1 got %b exp %b", i, uf1, e.uf); end
        end
    endtask

    task automatic test_raw_stall();
        stim_t st[5]; exp_t ex[5]; exp_t e;
        st[0] = mk(0, 1, 1, 0, 5, 0, 0, 0, 0, 0); ex[0] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        st[1] = mk(0, 1, 0, 0, 0, 5, 0, 0, 0, 0); ex[1] = '{1'b1, 1'b0, 16'h0020, 1'b0};
        st[2] = mk(0, 1, 0, 0, 0, 5, 0, 0, 0, 0); ex[2] = '{1'b1, 1'b0, 16'h0020, 1'b0};
        st[3] = mk(0, 1, 0, 0, 0, 5, 0, 0, 1, 5); ex[3] = '{1'b1, 1'b0, 16'h0020, 1'b0};
        st[4] = mk(0, 1, 0, 0, 0, 5, 0, 0, 0, 0); ex[4] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
            #2; e = sb.pop_front();
            checks++; if (hazard0 !== e.haz) begin errors++; $display("FAIL raw[%0d] hazard got %b exp %b", i, hazard0, e.haz); end
            checks++; if (fire0 !== e.fire)  begin errors++; $display("FAIL raw[%0d] fire got %b exp %b", i, fire0, e.fire); end
            checks++; if (busy0 !== e.busy)  begin errors++; $display("FAIL raw[%0d] busy got %h exp %h", i, busy0, e.busy); end
            checks++; if (uf0 !== e.uf)      begin errors++; $display("FAIL raw[%0d] uf got %b exp %b", i, uf0, e.uf); end
        end
    endtask

    task automatic test_two_src();
        stim_t st[3]; exp_t ex[3]; exp_t e;
        st[0] = mk(0, 1, 1, 0, 7, 0, 0, 0, 0, 0); ex[0] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        st[1] = mk(0, 1, 0, 0, 0, 0, 7, 0, 0, 0); ex[1] = '{1'b0, 1'b1, 16'h0080, 1'b0};
        st[2] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0); ex[2] = '{1'b1, 1'b0, 16'h0080, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
            #2; e = sb.pop_front();
            checks++; if (hazard0 !== e.haz) begin errors++; $display("FAIL two_src[%0d] hazard got %b exp %b", i, hazard0, e.haz); end
            checks++; if (fire0 !== e.fire)  begin errors++; $display("FAIL two_src[%0d] fire got %b exp %b", i, fire0, e.fire); end
            checks++; if (busy0 !== e.busy)  begin errors++; $display("FAIL two_src[%0d] busy got %h exp %h", i, busy0, e.busy); end
        end
    endtask

    task automatic test_load_use();
        stim_t st[7]; exp_t ex[7]; exp_t e;
        st[0] = mk(0, 1, 1, 1, 2, 0, 0, 0, 0, 0); ex[0] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        st[1] = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0); ex[1] = '{1'b1, 1'b0, 16'h0004, 1'b0};
        st[2] = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0); ex[2] = '{1'b0, 1'b1, 16'h0004, 1'b0};
        st[3] = mk(0, 1, 1, 0, 2, 0, 0, 0, 0, 0); ex[3] = '{1'b0, 1'b1, 16'h0004, 1'b0};
        st[4] = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0); ex[4] = '{1'b0, 1'b1, 16'h0004, 1'b0};
        st[5] = mk(0, 1, 1, 1, 3, 0, 0, 0, 0, 0); ex[5] = '{1'b0, 1'b1, 16'h0004, 1'b0};
        st[6] = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0); ex[6] = '{1'b1, 1'b0, 16'h000C, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
            #2; e = sb.pop_front();
            checks++; if (hazard1 !== e.haz) begin errors++; $display("FAIL load_use[%0d] hazard got %b exp %b", i, hazard1, e.haz); end
            checks++; if (fire1 !== e.fire)  begin errors++; $display("FAIL load_use[%0d] fire got %b exp %b", i, fire1, e.fire); end
            checks++; if (busy1 !== e.busy)  begin errors++; $display("FAIL load_use[%0d] busy got %h exp %h", i, busy1, e.busy); end
        end
    endtask

    task automatic test_saturation();
        stim_t st[6]; exp_t ex[6]; exp_t e;
        st[0] = mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0); ex[0] = '{1'b0, 1'b1, 16'h0000, 1'b0};
        st[1] = mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0); ex[1] = '{1'b0, 1'b1, 16'h0200, 1'b0};
        st[2] = mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0); ex[2] = '{1'b0, 1'b1, 16'h0200, 1'b0};
        st[3] = mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0); ex[3] = '{1'b1, 1'b0, 16'h0200, 1'b0};
        st[4] = mk(0, 1, 1, 0, 9, 0, 0, 0, 1, 9); ex[4] = '{1'b0, 1'b1, 16'h0200, 1'b0};
        st[5] = mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0); ex[5] = '{1'b1, 1'b0, 16'h0200, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
            #2; e = sb.pop_front();
            checks++; if (hazard0 !== e.haz) begin errors++; $display("FAIL sat[%0d] hazard got %b exp %b", i, hazard0, e.haz); end
            checks++; if (fire0 !== e.fire)  begin errors++; $display("FAIL sat[%0d] fire got %b exp %b", i, fire0, e.fire); end
            checks++; if (busy0 !== e.busy)  begin errors++; $display("FAIL sat[%0d] busy got %h exp %h", i, busy0, e.busy); end
            checks++; if (uf0 !== e.uf)      begin errors++; $display("FAIL sat[%0d] uf got %b exp %b", i, uf0, e.uf); end
        end
    endtask

    task automatic test_underflow_simul();
        stim_t st[8]; exp_t ex[8]; exp_t e;
        st[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4); ex[0] = '{1'b0, 1'b0, 16'h0000, 1'b0};
        st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[1] = '{1'b0, 1'b0, 16'h0000, 1'b1};
        st[2] = mk(0, 1, 1, 0, 6, 0, 0, 0, 0, 0); ex[2] = '{1'b0, 1'b1, 16'h0000, 1'b1};
        st[3] = mk(0, 1, 1, 0, 6, 0, 0, 0, 1, 6); ex[3] = '{1'b0, 1'b1, 16'h0040, 1'b1};
        st[4] = mk(0, 0, 0, 0, 0, 6, 0, 0, 1, 6); ex[4] = '{1'b0, 1'b0, 16'h0040, 1'b1};
        st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[5] = '{1'b0, 1'b0, 16'h0000, 1'b1};
        st[6] = mk(1, 1, 1, 0, 1, 0, 0, 0, 1, 4); ex[6] = '{1'b0, 1'b1, 16'h0000, 1'b1};
        st[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[7] = '{1'b0, 1'b0, 16'h0000, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
            #2; e = sb.pop_front();
            checks++; if (hazard0 !== e.haz) begin errors++; $display("FAIL uf_simul[%0d] hazard got %b exp %b", i, hazard0, e.haz); end
            checks++; if (fire0 !== e.fire)  begin errors++; $display("FAIL uf_simul[%0d] fire got %b exp %b", i, fire0, e.fire); end
            checks++; if (busy0 !== e.busy)  begin errors++; $display("FAIL uf_simul[%0d] busy got %h exp %h", i, busy0, e.busy); end
            checks++; if (uf0 !== e.uf)      begin errors++; $display("FAIL uf_simul[%0d] uf got %b exp %b", i, uf0, e.uf); end
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_two_src();
        test_load_use();
        test_saturation();
        test_underflow_simul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
